// File: rtl/brick_score_tx.sv
// Producer side of the 2-bit score link: tracks live bricks, counts new kills, queues and drains points.
// Optional macro SCORE_BONUS_EN adds BONUS points when the last brick of a level dies.
module brick_score_tx #(
  parameter int NUM_BRICKS = 16,
  parameter int PEND_W     = 6,
  parameter int BONUS      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_level,
  input  logic [NUM_BRICKS-1:0] hit,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [1:0]            total_score,
  output logic [PEND_W-1:0]     pending,
  output logic                  level_done,
  output logic                  overflow
);

`ifdef SCORE_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  localparam int CNT_W  = $clog2(NUM_BRICKS + 1);
  localparam int BON_W  = $clog2(BONUS + 1);
  localparam int MAX_W  = (PEND_W > CNT_W) ? ((PEND_W > BON_W) ? PEND_W : BON_W)
                                           : ((CNT_W > BON_W) ? CNT_W : BON_W);
  // Three addends each below 2**MAX_W can never carry past MAX_W+2 bits.
  localparam int SUM_W  = MAX_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [NUM_BRICKS-1:0] alive_r, alive_next_s, kills_s;
  logic [CNT_W-1:0]      newpts_s;
  logic                  last_kill_s;
  logic [SUM_W-1:0]      bonus_s, sum_s, rem_s;
  logic [1:0]            score_r, score_s;
  logic [PEND_W-1:0]     pend_r, pend_next_s;
  logic                  sat_s, done_r, ovf_r;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_BRICKS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Kill filter, points arithmetic and level state transitions
  always_comb begin
    kills_s      = '0;
    alive_next_s = alive_r;
    last_kill_s  = 1'b0;
    state_next_s = state_r;

    if (!clear_level && (state_r == PLAY || state_r == DRAIN)) begin
      kills_s      = hit & alive_r;
      alive_next_s = alive_r & ~hit;
      last_kill_s  = (state_r == PLAY) && (alive_next_s == '0);
    end else begin
      kills_s      = '0;
    end

    newpts_s = popcount(kills_s);
    bonus_s  = (BONUS_ON && last_kill_s) ? SUM_W'(BONUS) : '0;
    sum_s    = SUM_W'(pend_r) + SUM_W'(newpts_s) + bonus_s;
    score_s  = (sum_s > SUM_W'(2'd3)) ? 2'd3 : sum_s[1:0];
    rem_s    = sum_s - SUM_W'(score_s);
    sat_s    = rem_s > SUM_W'((2 ** PEND_W) - 1);
    if (sat_s) begin
      pend_next_s = '1;
    end else begin
      pend_next_s = rem_s[PEND_W-1:0];
    end

    if (clear_level) begin
      state_next_s = PLAY;
      alive_next_s = '1;
    end else begin
      case (state_r)
        IDLE:    state_next_s = IDLE;
        PLAY:    state_next_s = last_kill_s ? DRAIN : PLAY;
        DRAIN:   state_next_s = (sum_s == '0 && score_r == 2'd0) ? DONE : DRAIN;
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, brick map and points registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      alive_r <= '0;
      score_r <= 2'd0;
      pend_r  <= '0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      alive_r <= alive_next_s;
      score_r <= score_s;
      pend_r  <= pend_next_s;
      done_r  <= (state_next_s == DONE);
      ovf_r   <= ovf_r | sat_s;
    end
  end

  assign brick_alive = alive_r;
  assign total_score = score_r;
  assign pending     = pend_r;
  assign level_done  = done_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_brick_score_tx.sv
// Self-checking bench for brick_score_tx: directed scenarios plus random play against a level-based model.
module tb_brick_score_tx;

`ifdef SCORE_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] alive;
    int          phase;  // 0 idle, 1 play, 2 drain, 3 done
    int          pend;
    int          score;
    bit          ovf;
  } model_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_level = 1'b0;
  logic [15:0] hit = 16'h0;
  logic [15:0] alive6, alive3;
  logic [1:0]  score6, score3;
  logic [5:0]  pend6;
  logic [2:0]  pend3;
  logic        done6, done3, ovf6, ovf3;

  int checks = 0;
  int failures = 0;
  model_t m6, m3;

  brick_score_tx #(.NUM_BRICKS(16), .PEND_W(6), .BONUS(5)) dut6 (
    .clk(clk), .reset(reset), .clear_level(clear_level), .hit(hit),
    .brick_alive(alive6), .total_score(score6), .pending(pend6),
    .level_done(done6), .overflow(ovf6));

  brick_score_tx #(.NUM_BRICKS(16), .PEND_W(3), .BONUS(5)) dut3 (
    .clk(clk), .reset(reset), .clear_level(clear_level), .hit(hit),
    .brick_alive(alive3), .total_score(score3), .pending(pend3),
    .level_done(done3), .overflow(ovf3));

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t m;
    m.alive = 16'h0; m.phase = 0; m.pend = 0; m.score = 0; m.ovf = 1'b0;
    return m;
  endfunction

  function automatic model_t step(model_t m, bit cl, logic [15:0] h, int pmax);
    model_t n = m;
    int kills = 0;
    int sum;
    bit last = 1'b0;
    logic [15:0] left = m.alive;
    if (!cl && (m.phase == 1 || m.phase == 2)) begin
      kills = $countones(h & m.alive);
      left  = m.alive & ~h;
      last  = (m.phase == 1) && (left == 16'h0);
    end
    sum = m.pend + kills + ((BONUS_ON && last) ? 5 : 0);
    n.score = (sum < 3) ? sum : 3;
    if (sum - n.score > pmax) begin
      n.pend = pmax;
      n.ovf  = 1'b1;
    end else begin
      n.pend = sum - n.score;
    end
    n.alive = cl ? 16'hFFFF : left;
    if (cl) n.phase = 1;
    else if (last) n.phase = 2;
    else if (m.phase == 2 && sum == 0 && m.score == 0) n.phase = 3;
    return n;
  endfunction

  task automatic cycle(input bit cl, input logic [15:0] h);
    clear_level = cl;
    hit = h;
    @(posedge clk);
    m6 = step(m6, cl, h, 63);
    m3 = step(m3, cl, h, 7);
    @(negedge clk);
    clear_level = 1'b0;
    hit = 16'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    m6 = model_reset();
    m3 = model_reset();
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m6 = model_reset();
    m3 = model_reset();
    #3;
    checks++; if (alive6 !== 16'h0) begin failures++; $display("FAIL rst_alive got=%h exp=0000", alive6); end
    checks++; if (score6 !== 2'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", score6); end
    checks++; if (pend6 !== 6'd0) begin failures++; $display("FAIL rst_pend got=%0d exp=0", pend6); end
    checks++; if (done6 !== 1'b0 || ovf6 !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", done6, ovf6); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cycle(1'b0, 16'hFFFF);
    checks++; if (alive6 !== 16'h0) begin failures++; $display("FAIL idle_hit_alive got=%h exp=0000", alive6); end
    checks++; if (score6 !== 2'd0 || pend6 !== 6'd0) begin failures++; $display("FAIL idle_hit_score got=%0d/%0d exp=0/0", score6, pend6); end
    checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL idle_done got=%b exp=0", done6); end
  endtask

  task automatic test_single_kill();
    apply_reset();
    cycle(1'b1, 16'h0);
    checks++; if (alive6 !== 16'hFFFF || score6 !== 2'd0) begin failures++; $display("FAIL clear_alive got=%h/%0d exp=ffff/0", alive6, score6); end
    cycle(1'b0, 16'h0001);
    checks++; if (score6 !== 2'd1) begin failures++; $display("FAIL single_score got=%0d exp=1", score6); end
    checks++; if (alive6 !== 16'hFFFE) begin failures++; $display("FAIL single_alive got=%h exp=fffe", alive6); end
    cycle(1'b0, 16'h0);
    checks++; if (score6 !== 2'd0) begin failures++; $display("FAIL single_after got=%0d exp=0", score6); end
  endtask

  task automatic test_multi_kill();
    int exp_s[3] = '{3, 2, 0};
    int exp_p[3] = '{2, 0, 0};
    apply_reset();
    cycle(1'b1, 16'h0);
    cycle(1'b0, 16'h001F);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle(1'b0, 16'h0);
      checks++; if (score6 !== 2'(exp_s[i])) begin failures++; $display("FAIL multi_score[%0d] got=%0d exp=%0d", i, score6, exp_s[i]); end
      checks++; if (pend6 !== 6'(exp_p[i])) begin failures++; $display("FAIL multi_pend[%0d] got=%0d exp=%0d", i, pend6, exp_p[i]); end
    end
    cycle(1'b0, 16'h0001);
    checks++; if (score6 !== 2'd0) begin failures++; $display("FAIL dead_brick_score got=%0d exp=0", score6); end
    checks++; if (alive6 !== 16'hFFE0) begin failures++; $display("FAIL dead_brick_alive got=%h exp=ffe0", alive6); end
  endtask

  task automatic test_full_clear();
    int exp_q[$];
    if (BONUS_ON) exp_q = '{3, 3, 3, 3, 3, 3, 3, 0};
    else          exp_q = '{3, 3, 3, 3, 3, 1, 0};
    apply_reset();
    cycle(1'b1, 16'h0);
    cycle(1'b0, 16'hFFFF);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) cycle(1'b0, 16'h0);
      checks++; if (score6 !== 2'(exp_q[i])) begin failures++; $display("FAIL full_score[%0d] got=%0d exp=%0d", i, score6, exp_q[i]); end
      checks++; if (done6 !== 1'b0) begin failures++; $display("FAIL full_done_early[%0d] got=%b exp=0", i, done6); end
    end
    checks++; if (alive6 !== 16'h0) begin failures++; $display("FAIL full_alive got=%h exp=0000", alive6); end
    cycle(1'b0, 16'h0);
    checks++; if (done6 !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done6); end
    cycle(1'b0, 16'hFFFF);
    checks++; if (done6 !== 1'b1 || score6 !== 2'd0) begin failures++; $display("FAIL done_hold got=%b/%0d exp=1/0", done6, score6); end
    cycle(1'b1, 16'h0);
    checks++; if (done6 !== 1'b0 || alive6 !== 16'hFFFF) begin failures++; $display("FAIL relevel got=%b/%h exp=0/ffff", done6, alive6); end
  endtask

  task automatic test_overflow();
    int exp_s[5] = '{3, 3, 3, 1, 0};
    int exp_p[5] = '{7, 4, 1, 0, 0};
    apply_reset();
    checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL ovf_reset got=%b exp=0", ovf3); end
    cycle(1'b1, 16'h0);
    cycle(1'b0, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle(1'b0, 16'h0);
      checks++; if (score3 !== 2'(exp_s[i])) begin failures++; $display("FAIL ovf_score[%0d] got=%0d exp=%0d", i, score3, exp_s[i]); end
      checks++; if (pend3 !== 3'(exp_p[i])) begin failures++; $display("FAIL ovf_pend[%0d] got=%0d exp=%0d", i, pend3, exp_p[i]); end
      checks++; if (ovf3 !== 1'b1) begin failures++; $display("FAIL ovf_sticky[%0d] got=%b exp=1", i, ovf3); end
    end
    checks++; if (ovf6 !== 1'b0) begin failures++; $display("FAIL ovf_wide got=%b exp=0", ovf6); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    cycle(1'b1, 16'h0);
    cycle(1'b0, 16'h00FF);
    checks++; if (score6 !== 2'd3 || pend6 !== 6'd5) begin failures++; $display("FAIL pre_rst got=%0d/%0d exp=3/5", score6, pend6); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (score6 !== 2'd0) begin failures++; $display("FAIL async_score got=%0d exp=0", score6); end
    checks++; if (pend6 !== 6'd0) begin failures++; $display("FAIL async_pend got=%0d exp=0", pend6); end
    checks++; if (alive6 !== 16'h0) begin failures++; $display("FAIL async_alive got=%h exp=0000", alive6); end
    m6 = model_reset();
    m3 = model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 16'h0001);
    checks++; if (alive6 !== 16'hFFFF || score6 !== 2'd0) begin failures++; $display("FAIL clear_wins got=%h/%0d exp=ffff/0", alive6, score6); end
    cycle(1'b0, 16'h0);
    checks++; if (score6 !== 2'd0 || pend6 !== 6'd0) begin failures++; $display("FAIL clear_wins_pts got=%0d/%0d exp=0/0", score6, pend6); end
  endtask

  task automatic test_random();
    bit cl;
    logic [15:0] h;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      cl = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       h = 16'($urandom);
        1:       h = 16'h0;
        default: h = 16'($urandom & $urandom & $urandom);
      endcase
      cycle(cl, h);
      checks++; if (alive6 !== m6.alive) begin failures++; $display("FAIL rnd_alive[%0d] got=%h exp=%h", n, alive6, m6.alive); end
      checks++; if (score6 !== 2'(m6.score)) begin failures++; $display("FAIL rnd_score[%0d] got=%0d exp=%0d", n, score6, m6.score); end
      checks++; if (pend6 !== 6'(m6.pend)) begin failures++; $display("FAIL rnd_pend[%0d] got=%0d exp=%0d", n, pend6, m6.pend); end
      checks++; if (done6 !== (m6.phase == 3)) begin failures++; $display("FAIL rnd_done[%0d] got=%b exp=%b", n, done6, m6.phase == 3); end
      checks++; if (score3 !== 2'(m3.score) || pend3 !== 3'(m3.pend)) begin failures++; $display("FAIL rnd_narrow[%0d] got=%0d/%0d exp=%0d/%0d", n, score3, pend3, m3.score, m3.pend); end
      checks++; if (ovf3 !== m3.ovf || ovf6 !== m6.ovf) begin failures++; $display("FAIL rnd_ovf[%0d] got=%b%b exp=%b%b", n, ovf3, ovf6, m3.ovf, m6.ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single_kill();
    test_multi_kill();
    test_full_clear();
    test_overflow();
    test_reset_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
